// File: rtl/sys_arr_pkg.sv
// -----------------------------------------------------------------------------
// sys_arr_pkg
// Shared types for the systolic-array datapath. This file holds the pieces used
// by the accumulation sequencer:
//   fp16_t             raw IEEE-754 binary16 bit pattern (never inspected here)
//   accum_seq_state_t  sequencer FSM states
//   FP16_POS_INF       +infinity pattern, the result of an overflowing add
//   seq_term_is_last   decides whether an accepted term closes a reduction
// -----------------------------------------------------------------------------
package sys_arr_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ACCEPT,
        SEQ_ISSUE,
        SEQ_WAIT,
        SEQ_DONE
    } accum_seq_state_t;

    localparam fp16_t FP16_POS_INF = 16'h7C00;

    // A term ends the reduction if the producer flags it, or if it is the
    // term that brings the count up to the maximum (term_idx is 1-based).
    function automatic logic seq_term_is_last(input logic        in_last,
                                              input int unsigned term_idx,
                                              input int unsigned max_terms);
        return in_last || (term_idx >= max_terms);
    endfunction

endpackage

// File: rtl/sysarr_seq_timer.sv
// -----------------------------------------------------------------------------
// sysarr_seq_timer
// Watchdog counter for an outstanding add. Counts up while enabled, holds at
// TIMEOUT, and flags expired while the count equals TIMEOUT.
// Ports:
//   clk      in   clock, rising edge
//   RST      in   async reset, active-high
//   clr      in   synchronous clear (has priority over en)
//   en       in   count enable
//   expired  out  count has reached TIMEOUT
// -----------------------------------------------------------------------------
module sysarr_seq_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] tmr;

    assign expired = (tmr == TMR_W'(TIMEOUT));

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            tmr <= '0;
        end else if (clr) begin
            tmr <= '0;
        end else if (en && !expired) begin
            tmr <= tmr + 1'b1;
        end
    end

endmodule

// File: rtl/sysarr_accum_seq.sv
// -----------------------------------------------------------------------------
// sysarr_accum_seq
// Initiator side of the FP16 adder interface. Accepts a stream of FP16 partial
// sums, folds them one at a time into a running accumulator through the
// external pipelined adder (one add in flight at most), and presents the final
// sum on a valid/ready output.
// Ports:
//   clk, RST                  clock / async active-high reset
//   in_valid/in_ready         term handshake; in_data = term, in_last = final term
//   out_valid/out_ready       result handshake; out_data = sum,
//                             out_count = terms summed, out_err = add timed out
//   add_start                 one-cycle pulse launching an add
//   add_in1/add_in2           accumulator / new-term operands (stable while waiting)
//   add_out/add_ready         adder result and its one-cycle valid pulse
// -----------------------------------------------------------------------------
module sysarr_accum_seq
    import sys_arr_pkg::*;
#(
    parameter int MAX_TERMS = 16,
    parameter int TIMEOUT   = 15,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output logic             add_start,
    output logic [15:0]      add_in1,
    output logic [15:0]      add_in2,
    input  logic [15:0]      add_out,
    input  logic             add_ready
);

    accum_seq_state_t state;
    fp16_t            acc;
    fp16_t            opnd;
    logic [CNT_W-1:0] count;
    logic             last_q;
    logic             err;

    logic in_hs;
    logic first_last;
    logic next_last;
    logic tmr_en;
    logic tmr_clr;
    logic tmr_expired;

    assign in_hs      = in_valid && in_ready;
    assign first_last = seq_term_is_last(in_last, 32'd1, MAX_TERMS);
    assign next_last  = seq_term_is_last(in_last, 32'(count) + 32'd1, MAX_TERMS);

    // The timer already runs during ISSUE, so it reads 1 on the first WAIT
    // cycle and expires on the TIMEOUT-th WAIT cycle without add_ready.
    assign tmr_en  = (state == SEQ_ISSUE) || (state == SEQ_WAIT);
    assign tmr_clr = !tmr_en || ((state == SEQ_WAIT) && add_ready);

    sysarr_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .RST     (RST),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Operands and results are wired straight from the registers, so they are
    // inherently stable in WAIT and DONE.
    assign out_data  = acc;
    assign out_count = count;
    assign out_err   = err;
    assign add_in1   = acc;
    assign add_in2   = opnd;

    // Handshake outputs are registered and set together with the next state.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= SEQ_IDLE;
            acc       <= '0;
            opnd      <= '0;
            count     <= '0;
            last_q    <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            add_start <= 1'b0;
        end else begin
            add_start <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        // First term seeds the accumulator without an add.
                        acc   <= in_data;
                        count <= CNT_W'(1);
                        if (first_last) begin
                            state     <= SEQ_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SEQ_ACCEPT;
                        end
                    end
                end
                SEQ_ACCEPT: begin
                    if (in_hs) begin
                        opnd      <= in_data;
                        last_q    <= next_last;
                        count     <= count + 1'b1;
                        in_ready  <= 1'b0;
                        add_start <= 1'b1;
                        state     <= SEQ_ISSUE;
                    end
                end
                SEQ_ISSUE: begin
                    state <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    // add_ready takes priority over a coincident timeout.
                    if (add_ready) begin
                        acc <= add_out;
                        if (last_q) begin
                            state     <= SEQ_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= SEQ_ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end else if (tmr_expired) begin
                        err       <= 1'b1;
                        state     <= SEQ_DONE;
                        out_valid <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    if (out_ready) begin
                        acc       <= '0;
                        count     <= '0;
                        err       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= SEQ_IDLE;
                    end
                end
                default: begin
                    state     <= SEQ_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysarr_accum_seq.sv
// -----------------------------------------------------------------------------
// tb_sysarr_accum_seq
// Self-checking bench for sysarr_accum_seq. A behavioural FP16 adder stub
// answers add requests; a reduction model (plain real-number FP16 arithmetic
// folded over the term list) predicts each result, and a per-cycle compare
// process checks the DUT outputs against the expected-result queue.
// -----------------------------------------------------------------------------
module tb_sysarr_accum_seq;
    import sys_arr_pkg::*;

    localparam int MAX_TERMS = 16;
    localparam int TIMEOUT   = 15;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);

    logic             clk = 1'b0;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;
    logic             add_start;
    logic [15:0]      add_in1;
    logic [15:0]      add_in2;
    logic [15:0]      add_out;
    logic             add_ready;

    always #5 clk = ~clk;

    sysarr_accum_seq #(
        .MAX_TERMS (MAX_TERMS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err),
        .add_start (add_start),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_out   (add_out),
        .add_ready (add_ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] d;
        int          c;
        logic        e;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] terms[16];

    // Stub adder / consumer controls
    int          stub_lat_min = 0;
    int          stub_lat_max = 0;
    bit          stub_noresp  = 0;
    bit          stray_req    = 0;
    logic [15:0] stray_val    = 16'h0;
    bit          hold_out     = 0;
    int          rdy_pct      = 100;

    // Observations from the compare process
    int start_cnt       = 0;
    int last_start_cyc  = 0;
    int first_valid_cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- FP16 reference arithmetic ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real fp16_to_real(input logic [15:0] h);
        real v;
        int  e;
        int  m;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 0) v = $itor(m) * pow2(-24);
        else        v = $itor(m + 1024) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real r);
        logic s;
        real  a;
        real  sc;
        int   e;
        int   m;
        s = (r < 0.0);
        a = s ? -r : r;
        if (a == 0.0) return 16'h0000;
        e  = 0;
        sc = 1.0;
        while (a >= 2.0 * sc) begin sc = sc * 2.0; e++; end
        while (a < sc)        begin sc = sc / 2.0; e--; end
        if (e < -14) begin
            m = $rtoi(a * 16777216.0 + 0.5);
            return {s, 15'(m)};
        end
        m = $rtoi((a / sc - 1.0) * 1024.0 + 0.5);
        if (m == 1024) begin m = 0; e++; end
        if (e > 15) return {s, 5'h1F, 10'h000};
        return {s, 5'(e + 15), 10'(m)};
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        return real_to_fp16(fp16_to_real(a) + fp16_to_real(b));
    endfunction

    function automatic logic [15:0] rnd_term();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)), 10'($urandom_range(0, 1023))};
    endfunction

    // ---------------- cycle counter ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- behavioural adder stub ----------------
    initial begin
        bit          pend;
        int          wcnt;
        logic [15:0] res;
        logic [15:0] cap1;
        logic [15:0] cap2;
        pend      = 0;
        wcnt      = 0;
        res       = 16'h0;
        cap1      = 16'h0;
        cap2      = 16'h0;
        add_ready = 1'b0;
        add_out   = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            add_ready = 1'b0;
            if (RST) begin
                pend = 0;
            end else begin
                if (pend) begin
                    chk("add_in1_stable", 32'(add_in1), 32'(cap1));
                    chk("add_in2_stable", 32'(add_in2), 32'(cap2));
                    if (wcnt == 0) begin
                        add_ready = 1'b1;
                        add_out   = res;
                        pend      = 0;
                    end else begin
                        wcnt--;
                    end
                end else if (stray_req) begin
                    add_ready = 1'b1;
                    add_out   = stray_val;
                    stray_req = 0;
                end
                if (add_start) begin
                    chk("add_start_while_busy", 32'(pend), 32'd0);
                    cap1 = add_in1;
                    cap2 = add_in2;
                    res  = fp16_add(add_in1, add_in2);
                    if (!stub_noresp) begin
                        pend = 1;
                        wcnt = $urandom_range(stub_lat_max, stub_lat_min);
                    end
                end
            end
        end
    end

    // ---------------- consumer ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = !hold_out && ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit prev_hs;
        bit prev_valid;
        bit prev_start;
        prev_hs    = 0;
        prev_valid = 0;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (RST) begin
                chk("reset_ctrl", 32'({in_ready, out_valid, out_err, add_start}), 32'd0);
                chk("reset_data", 32'({out_data, out_count}), 32'd0);
                chk("reset_add_ops", {add_in1, add_in2}, 32'd0);
                prev_hs    = 0;
                prev_valid = 0;
                prev_start = 0;
            end else begin
                if (add_start) begin
                    start_cnt++;
                    last_start_cyc = cyc;
                    chk("add_start_one_cycle", 32'(prev_start), 32'd0);
                end
                if (prev_hs) begin
                    chk("release_out_valid", 32'(out_valid), 32'd0);
                    chk("release_in_ready", 32'(in_ready), 32'd1);
                end
                if (out_valid) begin
                    if (!prev_valid) first_valid_cyc = cyc;
                    chk("done_in_ready", 32'(in_ready), 32'd0);
                    chk("done_add_start", 32'(add_start), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("out_valid_unexpected", 32'(out_valid), 32'd0);
                    end else begin
                        chk("out_data", 32'(out_data), 32'(exp_q[0].d));
                        chk("out_count", 32'(out_count), 32'(exp_q[0].c));
                        chk("out_err", 32'(out_err), 32'(exp_q[0].e));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                prev_hs    = out_valid && out_ready;
                prev_valid = out_valid;
                prev_start = add_start;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last, output int acc_cyc);
        bit ok;
        ok       = 0;
        acc_cyc  = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok      = 1;
                acc_cyc = cyc;
                break;
            end
        end
        if (!ok) chk("in_handshake_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
    endtask

    // Send terms[0..n-1]; optionally push the modelled result.
    task automatic reduce(input int n, input bit gaps, input bit push_exp, output int k0);
        logic [15:0] acc;
        int          k;
        logic        last;
        k0 = 0;
        if (push_exp) begin
            acc = terms[0];
            for (int i = 1; i < n; i++) acc = fp16_add(acc, terms[i]);
            exp_q.push_back('{d: acc, c: n, e: 1'b0});
        end
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1) && ((n < MAX_TERMS) || ($urandom_range(0, 1) == 1));
            send(terms[i], last, k);
            if (i == 0) k0 = k;
            if (gaps) step($urandom_range(0, 2));
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int k0;
        int s0;
        int k;
        bit seen;

        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0;
        in_last  = 1'b0;
        step(3);
        RST = 1'b0;
        step(1);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Literal pins on the reference adder
        chk("model_1p2", 32'(fp16_add(16'h3C00, 16'h4000)), 32'h4200);
        chk("model_3p0p5", 32'(fp16_add(16'h4200, 16'h3800)), 32'h4300);
        chk("model_ovf", 32'(fp16_add(16'h7BFF, 16'h7BFF)), 32'h7C00);

        // T1: single term
        rdy_pct = 100;
        s0 = start_cnt;
        terms[0] = 16'h3C00;
        exp_q.push_back('{d: 16'h3C00, c: 1, e: 1'b0});
        reduce(1, 0, 0, k0);
        drain();
        chk("t1_latency", 32'(first_valid_cyc - k0), 32'd1);
        chk("t1_no_add_start", 32'(start_cnt - s0), 32'd0);

        // T2: three terms, adder answers 3 cycles after add_start
        stub_lat_min = 2;
        stub_lat_max = 2;
        s0 = start_cnt;
        terms[0] = 16'h3C00;
        terms[1] = 16'h4000;
        terms[2] = 16'h3800;
        exp_q.push_back('{d: 16'h4300, c: 3, e: 1'b0});
        reduce(3, 0, 0, k0);
        drain();
        chk("t2_latency", 32'(first_valid_cyc - k0), 32'(1 + 2 * (3 + 2)));
        chk("t2_add_starts", 32'(start_cnt - s0), 32'd2);
        stub_lat_min = 0;
        stub_lat_max = 0;

        // T3: backpressure in DONE, with a stray add_ready that must be ignored
        hold_out = 1;
        terms[0] = 16'h4400;
        exp_q.push_back('{d: 16'h4400, c: 1, e: 1'b0});
        reduce(1, 0, 0, k0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("t3_out_valid_seen", 32'(seen), 32'd1);
        step(4);
        stray_val = 16'h1234;
        stray_req = 1;
        step(6);
        chk("t3_still_valid", 32'(out_valid), 32'd1);
        chk("t3_data_held", 32'(out_data), 32'h4400);
        hold_out = 0;
        drain();

        // T4: overflow passes through as +inf
        terms[0] = 16'h7BFF;
        terms[1] = 16'h7BFF;
        exp_q.push_back('{d: FP16_POS_INF, c: 2, e: 1'b0});
        reduce(2, 0, 0, k0);
        drain();

        // T5: adder never answers
        stub_noresp = 1;
        terms[0] = 16'h3C00;
        terms[1] = 16'h4000;
        exp_q.push_back('{d: 16'h3C00, c: 2, e: 1'b1});
        reduce(2, 0, 0, k0);
        drain();
        chk("t5_timeout_cycles", 32'(first_valid_cyc - last_start_cyc), 32'(TIMEOUT + 1));
        stub_noresp = 0;

        // T6: reset while waiting for the adder, then a stray add_ready
        stub_noresp = 1;
        send(16'h3C00, 1'b0, k);
        send(16'h4000, 1'b0, k);
        chk("t6_add_start", 32'(add_start), 32'd1);
        step(1);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        stub_noresp = 0;
        step(2);
        stray_val = 16'h5555;
        stray_req = 1;
        step(4);
        chk("t6_idle_in_ready", 32'(in_ready), 32'd1);
        chk("t6_idle_out_valid", 32'(out_valid), 32'd0);
        terms[0] = 16'h4000;
        exp_q.push_back('{d: 16'h4000, c: 1, e: 1'b0});
        reduce(1, 0, 0, k0);
        drain();

        // Randomized reductions, including ones capped at MAX_TERMS
        rdy_pct      = 60;
        stub_lat_min = 0;
        stub_lat_max = 3;
        for (int r = 0; r < 25; r++) begin
            int n;
            n = (r % 6 == 5) ? MAX_TERMS : $urandom_range(1, MAX_TERMS);
            for (int i = 0; i < n; i++) terms[i] = rnd_term();
            reduce(n, 1, 1, k0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
